// File: rtl/ysyx_22040750_ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22040750_ifu_fetch
//  Description : Instruction fetch stage. Accepts the dynamic next PC from the
//                next-PC generator, issues one instruction-memory request at
//                a time, and holds the returned instruction in the IF/ID
//                register for decode. A redirect (flush) from a later stage
//                cancels the in-flight fetch and restarts at the flush target.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040750_ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h80000000,
    parameter int          INST_W   = 32
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_dnpc_valid,
    output logic              O_dnpc_ready,
    input  logic [31:0]       I_dnpc,
    input  logic              I_flush,
    input  logic [31:0]       I_flush_pc,
    output logic              O_imem_req_valid,
    input  logic              I_imem_req_ready,
    output logic [31:0]       O_imem_addr,
    input  logic              I_imem_resp_valid,
    input  logic [INST_W-1:0] I_imem_resp_data,
    output logic              O_IF_ID_valid,
    input  logic              I_IF_ID_ready,
    output logic [31:0]       O_IF_ID_pc,
    output logic [31:0]       O_IF_ID_snpc,
    output logic [INST_W-1:0] O_IF_ID_inst
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_FULL = 3'd3,
        S_NEXT = 3'd4
    } state_t;

    state_t              r_state;
    logic [31:0]         r_pc;
    logic                r_drop;   // the outstanding response belongs to a cancelled fetch
    logic                r_if_valid;
    logic [31:0]         r_if_pc;
    logic [31:0]         r_if_snpc;
    logic [INST_W-1:0]   r_if_inst;

    logic                w_req_hs;
    logic                w_ifid_hs;

    // Request side is decoded purely from registered state so memory never
    // sees a combinational path from this stage's inputs.
    assign O_imem_req_valid = (r_state == S_REQ);
    assign O_imem_addr      = r_pc;
    // A redirect must not let the stale dnpc be consumed.
    assign O_dnpc_ready     = (r_state == S_NEXT) && !I_flush;

    assign O_IF_ID_valid    = r_if_valid;
    assign O_IF_ID_pc       = r_if_pc;
    assign O_IF_ID_snpc     = r_if_snpc;
    assign O_IF_ID_inst     = r_if_inst;

    assign w_req_hs  = O_imem_req_valid && I_imem_req_ready;
    assign w_ifid_hs = r_if_valid && I_IF_ID_ready;

    // Fetch FSM, PC register and IF/ID pipeline register.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_drop     <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_pc    <= 32'd0;
            r_if_snpc  <= 32'd0;
            r_if_inst  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Flush is deliberately ignored here; the PC stays put.
                    r_state <= S_REQ;
                end
                S_REQ: begin
                    if (I_flush) begin
                        r_pc       <= I_flush_pc;
                        r_if_valid <= 1'b0;
                        if (w_req_hs) begin
                            // Old address already went out; swallow its reply.
                            r_state <= S_WAIT;
                            r_drop  <= 1'b1;
                        end
                    end else if (w_req_hs) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (I_flush) begin
                        r_pc       <= I_flush_pc;
                        r_if_valid <= 1'b0;
                        if (I_imem_resp_valid) begin
                            r_drop  <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_drop  <= 1'b1;
                        end
                    end else if (I_imem_resp_valid) begin
                        if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_if_valid <= 1'b1;
                            r_if_pc    <= r_pc;
                            r_if_snpc  <= r_pc + 32'd4;
                            r_if_inst  <= I_imem_resp_data;
                            r_state    <= S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (I_flush) begin
                        r_pc       <= I_flush_pc;
                        r_if_valid <= 1'b0;
                        r_state    <= S_REQ;
                    end else if (w_ifid_hs) begin
                        r_if_valid <= 1'b0;
                        r_state    <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (I_flush) begin
                        r_pc       <= I_flush_pc;
                        r_if_valid <= 1'b0;
                        r_state    <= S_REQ;
                    end else if (I_dnpc_valid) begin
                        r_pc    <= I_dnpc;
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/ysyx_22040750_ifu_fetch.md
Name: ysyx_22040750_ifu_fetch

Overview:
Instruction fetch stage that sits directly downstream of the next-PC generator. It consumes the dynamic next PC (dnpc) through a valid/ready handshake, holds it in the PC register, and issues one instruction-memory request at a time. It captures the returned instruction into the IF/ID pipeline register and presents pc/snpc/inst to decode with a valid/ready handshake. It also supports a redirect (flush) from a later stage that cancels the in-flight fetch.

Parameters:
RESET_PC, 32'h80000000, PC fetched first after reset.
INST_W, 32, instruction width.

Ports:
I_clk  in  1  clock; all state updates on the rising edge.
I_rst  in  1  synchronous active-high reset.
I_dnpc_valid  in  1  next-PC generator has a valid dnpc.
O_dnpc_ready  out  1  stage accepts dnpc this cycle.
I_dnpc  in  32  next PC value.
I_flush  in  1  redirect request; overrides everything except reset.
I_flush_pc  in  32  redirect target.
O_imem_req_valid  out  1  fetch request valid.
I_imem_req_ready  in  1  memory accepts the request.
O_imem_addr  out  32  fetch address (= pc register).
I_imem_resp_valid  in  1  instruction data returned.
I_imem_resp_data  in  INST_W  returned instruction.
O_IF_ID_valid  out  1  IF/ID register holds a valid instruction.
I_IF_ID_ready  in  1  decode accepts it.
O_IF_ID_pc  out  32  pc of the held instruction.
O_IF_ID_snpc  out  32  O_IF_ID_pc + 4, computed mod 2^32.
O_IF_ID_inst  out  INST_W  held instruction.

Behaviour:
- States: IDLE, REQ, WAIT, FULL, NEXT. Handshakes occur when valid && ready are high in the same cycle.
- Reset:
  - state=IDLE, pc=RESET_PC, drop=0, O_IF_ID_valid=0.
  - O_IF_ID_pc/snpc/inst = 0.
  - All request and ready outputs = 0.
- IDLE: always moves to REQ the next cycle. This gives one dead cycle after reset deasserts.
- REQ:
  - O_imem_req_valid=1 and O_imem_addr=pc. Both are decoded from state/pc, with no combinational path from inputs.
  - On the req handshake, go to WAIT.
- WAIT:
  - Waits for I_imem_resp_valid.
  - If drop=0: capture pc, pc+4 and data into the IF/ID registers, set O_IF_ID_valid=1 the next cycle, and go to FULL. Load-to-output latency is 1 cycle.
  - If drop=1: discard the data, clear drop, and go to REQ.
  - A response outside WAIT is ignored.
- FULL:
  - IF/ID outputs are held stable while I_IF_ID_ready=0.
  - On the IF/ID handshake, O_IF_ID_valid goes to 0 and the state goes to NEXT.
- NEXT:
  - O_dnpc_ready=1, asserted only in NEXT and only while I_flush=0.
  - On the dnpc handshake, pc <= I_dnpc and the state goes to REQ.
  - dnpc is taken unmodified; any alignment is the upstream block's responsibility.
- Flush (I_flush=1) in any non-IDLE state: pc <= I_flush_pc the next cycle, and O_IF_ID_valid <= 0.
  - REQ, no handshake this cycle: stay in REQ. The address changes to flush_pc; the memory side permits this.
  - REQ with handshake the same cycle: go to WAIT with drop=1.
  - WAIT: drop=1 and stay in WAIT. If the response arrives in the same cycle, discard it and go directly to REQ with drop=0.
  - FULL: the instruction is discarded even if the IF/ID handshake happens the same cycle. Go to REQ.
  - NEXT: flush wins over dnpc. O_dnpc_ready is 0, dnpc is not consumed, and the state goes to REQ.
  - IDLE: flush is ignored; IDLE still goes to REQ with pc unchanged.
- Reset has priority over flush and all handshakes. Reset mid-WAIT returns to IDLE with drop=0.
  - A response arriving in IDLE or REQ is ignored.
  - A response arriving after the first post-reset request is accepted is taken as that request's data. The memory side must drain before the next request is accepted.
- At most one outstanding request, ever.

Test Plan:
1. Reset: I_rst=1 for 2 cycles, then 0. Cycle +1: req_valid=0 (IDLE). Cycle +2: req_valid=1, addr=0x80000000. All IF_ID outputs are 0 throughout.
2. Normal flow:
   - req_ready=1; the next cycle gives resp_valid=1, data=0x00000413.
   - The following cycle: IF_ID_valid=1, pc=0x80000000, snpc=0x80000004, inst=0x00000413.
   - IF_ID_ready=1 leads to NEXT with dnpc_ready=1.
   - dnpc=0x80000010 with valid=1 gives, the next cycle, req_valid=1 and addr=0x80000010.
3. Backpressure: hold IF_ID_ready=0 for 3 cycles with dnpc_valid=1. IF_ID outputs are unchanged, dnpc_ready stays 0, and no new request is issued.
4. Flush in WAIT: request accepted at 0x80000000; flush with pc 0x80000100; response 0xdeadbeef arrives 2 cycles later. It is not forwarded (IF_ID_valid stays 0). The next request has addr 0x80000100.
5. Flush coincident with dnpc_valid in NEXT: dnpc=0x80000008, flush_pc=0x80000200. dnpc_ready=0, and the next request has addr 0x80000200.
6. Flush in REQ with req_ready=1 the same cycle: the old request is accepted, then its response is dropped. A second request with addr=flush_pc follows, and its response is delivered with pc=flush_pc.
